// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory bus plus IF/ID pipeline-register outputs of the fetch stage.
// master = fetch unit, slave = memory/decode/hazard side.
interface instruction_fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, imem_instr,
    output imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
           halted, misaligned, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_instr,
    input  imem_addr, ifid_pc, ifid_pc4, ifid_instr, ifid_valid,
           halted, misaligned, fetch_count
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// fills the IF/ID register, with stall, redirect-with-bubble and out-of-window halt.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_BOOT | first cycle after reset; IF/ID holds the bubble, PC held
// S_RUN  | fetching one word per cycle
// S_HALT | PC left the memory window; bubble only, waits for redirect
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic        halted_q;
  logic        misaligned_q;
  logic [31:0] fetch_count_q;
  logic        next_oor;
  logic        redir_oor;

  assign pc_plus4  = pc + 32'd4;
  assign next_oor  = {2'b00, pc_plus4[31:2]} >= IMEM_LIMIT;
  assign redir_oor = {2'b00, bus.redirect_pc[31:2]} >= IMEM_LIMIT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_BOOT;
      pc            <= RESET_PC;
      ifid_pc_q     <= 32'd0;
      ifid_pc4_q    <= 32'd0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_valid_q  <= 1'b0;
      halted_q      <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      misaligned_q <= 1'b0;
      if (bus.redirect) begin
        pc           <= {bus.redirect_pc[31:2], 2'b00};
        ifid_pc_q    <= 32'd0;
        ifid_pc4_q   <= 32'd0;
        ifid_instr_q <= NOP_INSTR;
        ifid_valid_q <= 1'b0;
        misaligned_q <= |bus.redirect_pc[1:0];
        state        <= redir_oor ? S_HALT : S_RUN;
        halted_q     <= redir_oor;
      end else if (bus.stall && state != S_HALT) begin
        // hold everything
      end else begin
        case (state)
          S_BOOT: state <= S_RUN;
          S_RUN: begin
            ifid_pc_q     <= pc;
            ifid_pc4_q    <= pc_plus4;
            ifid_instr_q  <= bus.imem_instr;
            ifid_valid_q  <= 1'b1;
            pc            <= pc_plus4;
            fetch_count_q <= fetch_count_q + 32'd1;
            if (next_oor) begin
              state    <= S_HALT;
              halted_q <= 1'b1;
            end
          end
          S_HALT: begin
            // last in-window word is flushed to a bubble once halted
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end
          default: state <= S_BOOT;
        endcase
      end
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.ifid_pc     = ifid_pc_q;
  assign bus.ifid_pc4    = ifid_pc4_q;
  assign bus.ifid_instr  = ifid_instr_q;
  assign bus.ifid_valid  = ifid_valid_q;
  assign bus.halted      = halted_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table plus a full
// run-to-halt sequence, expectations queued at drive time and popped after the edge.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_halted;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [31:0] mem [64];
  int          checks;
  int          errors;
  vec_t        vecs [25];
  vec_t        exp_q [$];

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.imem_instr = (bus.imem_addr[31:8] == 24'd0) ? mem[bus.imem_addr[7:2]] : 32'hBAD0_0000;

  function automatic vec_t mk(input logic rst, stall, redir, input logic [31:0] rpc,
                              input logic [31:0] e_addr, e_pc, input logic e_valid,
                              e_halted, e_mis, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.redir = redir; v.rpc = rpc;
    v.e_addr = e_addr; v.e_pc = e_pc; v.e_valid = e_valid;
    v.e_halted = e_halted; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    vec_t e;
    logic [31:0] e_instr;
    @(negedge clk);
    reset           = v.rst;
    bus.stall       = v.stall;
    bus.redirect    = v.redir;
    bus.redirect_pc = v.rpc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    e_instr = e.e_valid ? mem[e.e_pc[7:2]] : NOP;
    chk({tag, " imem_addr"},   bus.imem_addr,   e.e_addr);
    chk({tag, " ifid_pc"},     bus.ifid_pc,     e.e_pc);
    chk({tag, " ifid_pc4"},    bus.ifid_pc4,    e.e_valid ? e.e_pc + 32'd4 : 32'd0);
    chk({tag, " ifid_instr"},  bus.ifid_instr,  e_instr);
    chk({tag, " ifid_valid"},  {31'd0, bus.ifid_valid}, {31'd0, e.e_valid});
    chk({tag, " halted"},      {31'd0, bus.halted},     {31'd0, e.e_halted});
    chk({tag, " misaligned"},  {31'd0, bus.misaligned}, {31'd0, e.e_mis});
    chk({tag, " fetch_count"}, bus.fetch_count, e.e_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 64; i++)
      mem[i] = 32'hA500_0000 ^ (i * 32'h0001_0203) ^ 32'(i);
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;

    //                rst stall redir rpc          addr         ifid_pc      vld hlt mis cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,        32'h0,       32'h0,       0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        32'h0,       32'h0,       0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        32'h4,       32'h0,       1, 0, 0, 1);
    vecs[3]  = mk(0, 0, 0, 32'h0,        32'h8,       32'h4,       1, 0, 0, 2);
    vecs[4]  = mk(0, 1, 0, 32'h0,        32'h8,       32'h4,       1, 0, 0, 2);
    vecs[5]  = mk(0, 1, 0, 32'h0,        32'h8,       32'h4,       1, 0, 0, 2);
    vecs[6]  = mk(0, 0, 0, 32'h0,        32'hC,       32'h8,       1, 0, 0, 3);
    vecs[7]  = mk(0, 0, 0, 32'h0,        32'h10,      32'hC,       1, 0, 0, 4);
    vecs[8]  = mk(0, 1, 1, 32'h40,       32'h40,      32'h0,       0, 0, 0, 4);
    vecs[9]  = mk(0, 0, 0, 32'h0,        32'h44,      32'h40,      1, 0, 0, 5);
    vecs[10] = mk(0, 0, 1, 32'h42,       32'h40,      32'h0,       0, 0, 1, 5);
    vecs[11] = mk(0, 0, 0, 32'h0,        32'h44,      32'h40,      1, 0, 0, 6);
    vecs[12] = mk(0, 1, 1, 32'h100,      32'h100,     32'h0,       0, 1, 0, 6);
    vecs[13] = mk(0, 0, 0, 32'h0,        32'h100,     32'h0,       0, 1, 0, 6);
    vecs[14] = mk(0, 1, 0, 32'h0,        32'h100,     32'h0,       0, 1, 0, 6);
    vecs[15] = mk(0, 0, 1, 32'h0,        32'h0,       32'h0,       0, 0, 0, 6);
    vecs[16] = mk(0, 0, 0, 32'h0,        32'h4,       32'h0,       1, 0, 0, 7);
    vecs[17] = mk(1, 1, 1, 32'h80,       32'h0,       32'h0,       0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,        32'h0,       32'h0,       0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 32'h0,        32'h4,       32'h0,       1, 0, 0, 1);
    vecs[20] = mk(0, 0, 1, 32'h7,        32'h4,       32'h0,       0, 0, 1, 1);
    vecs[21] = mk(1, 0, 0, 32'h0,        32'h0,       32'h0,       0, 0, 0, 0);
    vecs[22] = mk(0, 1, 0, 32'h0,        32'h0,       32'h0,       0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 32'h0,        32'h0,       32'h0,       0, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 32'h0,        32'h4,       32'h0,       1, 0, 0, 1);

    for (int i = 0; i < 25; i++)
      apply($sformatf("v%0d", i), vecs[i]);

    // full run from reset to the end of the memory window
    apply("run rst",  mk(1, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0));
    apply("run boot", mk(0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < 64; i++)
      apply($sformatf("run w%0d", i),
            mk(0, 0, 0, 32'h0, 32'(4 * i + 4), 32'(4 * i), 1, (i == 63), 0, 32'(i + 1)));
    apply("halt stall",   mk(0, 1, 0, 32'h0,   32'h100, 32'h0,  0, 1, 0, 64));
    apply("halt idle",    mk(0, 0, 0, 32'h0,   32'h100, 32'h0,  0, 1, 0, 64));
    apply("halt exit",    mk(0, 0, 1, 32'hFC,  32'hFC,  32'h0,  0, 0, 0, 64));
    apply("last word",    mk(0, 0, 0, 32'h0,   32'h100, 32'hFC, 1, 1, 0, 65));
    apply("halt to halt", mk(0, 0, 1, 32'h105, 32'h104, 32'h0,  0, 1, 1, 65));
    apply("halt hold",    mk(0, 0, 0, 32'h0,   32'h104, 32'h0,  0, 1, 0, 65));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
